// File: rtl/cymometer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cymometer_pkg                                                |
// | Description : Shared constants for the frequency-counter measurement       |
// |               scheduler: FSM state encoding, gate-length codes, the        |
// |               overflow display value and the default low-range threshold.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cymometer_pkg;

   typedef logic [1:0] gate_t;

   // Scheduler states
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_EVAL  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   // Core gate-length codes; code 3 is illegal
   localparam gate_t GATE_10MS  = 2'd0;
   localparam gate_t GATE_100MS = 2'd1;
   localparam gate_t GATE_1S    = 2'd2;

   // Shown on the display when the core counter saturated
   localparam logic [19:0] C_OVF_DISP = 20'hFFFFF;

   // Results below this ask for a longer gate
   localparam logic [19:0] C_LO_THRESH_DEF = 20'd1000;

   localparam int C_TMR_W = 27;

endpackage : cymometer_pkg
`default_nettype wire

// File: rtl/cymometer_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : cymometer_sched_if                                           |
// | Description : Control/result bundle between the measurement scheduler and |
// |               the counter core.                                            |
// |   meas_start  sched->core  one-cycle measurement start pulse               |
// |   meas_abort  sched->core  one-cycle cancel pulse                          |
// |   gate_sel    sched->core  gate length code (0/1/2)                        |
// |   meas_done   core->sched  one-cycle result-valid pulse                    |
// |   meas_data   core->sched  measured frequency in Hz                        |
// |   meas_ovf    core->sched  counter saturated                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface cymometer_sched_if;
   import cymometer_pkg::*;

   logic        meas_start;
   logic        meas_abort;
   gate_t       gate_sel;
   logic        meas_done;
   logic [19:0] meas_data;
   logic        meas_ovf;

   // Scheduler side
   modport master (
      output meas_start, meas_abort, gate_sel,
      input  meas_done,  meas_data,  meas_ovf
   );

   // Counter-core side
   modport slave (
      input  meas_start, meas_abort, gate_sel,
      output meas_done,  meas_data,  meas_ovf
   );

endinterface : cymometer_sched_if
`default_nettype wire

// File: rtl/cymometer_sched_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sched_timer                                                  |
// | Description : Load/decrement down-counter shared by the WAIT timeout and  |
// |               the GAP idle period. Decrement stops at zero.                |
// |   sys_clk     in   clock                                                   |
// |   sys_rst_n   in   synchronous active-low reset                            |
// |   i_load      in   load i_load_val (has priority over i_dec)               |
// |   i_load_val  in   value to load                                           |
// |   i_dec       in   decrement by one when non-zero                          |
// |   o_zero      out  counter is zero                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sched_timer
   import cymometer_pkg::*;
#(
   parameter int WIDTH = C_TMR_W
) (
   input  wire logic             sys_clk,
   input  wire logic             sys_rst_n,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_load_val,
   input  wire logic             i_dec,
   output      logic             o_zero
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule : sched_timer
`default_nettype wire

// File: rtl/cymometer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cymometer_sched                                              |
// | Description : Measurement scheduler for the equal-precision frequency     |
// |               counter. Repeats measurements, auto-ranges the gate length, |
// |               detects a missing input by timeout and drives the display.  |
// |   sys_clk     in   clock                                                   |
// |   sys_rst_n   in   synchronous active-low reset                            |
// |   hold        in   1 freezes disp_data/disp_valid                          |
// |   bus         --   core control/result bundle (master side)                |
// |   disp_data   out  value for the seven-segment driver                      |
// |   disp_valid  out  a result has been published                             |
// |   no_signal   out  last measurement timed out                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cymometer_sched
   import cymometer_pkg::*;
#(
   parameter logic [25:0] GAP_CYC     = 26'd5_000_000,
   parameter logic [26:0] TIMEOUT_CYC = 27'd100_000_000,
   parameter logic [19:0] LO_THRESH   = C_LO_THRESH_DEF,
   parameter int          MAX_RERANGE = 2
) (
   input  wire logic          sys_clk,
   input  wire logic          sys_rst_n,
   input  wire logic          hold,
   cymometer_sched_if.master  bus,
   output      logic [19:0]   disp_data,
   output      logic          disp_valid,
   output      logic          no_signal
);

   localparam logic [1:0] C_MAX_RR = 2'(MAX_RERANGE);

   logic [2:0]          r_state;
   gate_t               r_gate;
   logic [1:0]          r_rr_cnt;
   logic [19:0]         r_data;
   logic                r_ovf;
   logic                r_meas_start;
   logic                r_meas_abort;
   logic [19:0]         r_disp_data;
   logic                r_disp_valid;
   logic                r_no_signal;

   logic                w_tmr_load;
   logic [C_TMR_W-1:0]  w_tmr_val;
   logic                w_tmr_dec;
   logic                w_tmr_zero;
   logic                w_rr_down;
   logic                w_rr_up;

   // Overflow wins over the low-range rule; both are bounded by the re-range budget
   assign w_rr_down = r_ovf && (r_gate != GATE_10MS) && (r_rr_cnt < C_MAX_RR);
   assign w_rr_up   = !w_rr_down && (r_data < LO_THRESH) &&
                      (r_gate < GATE_1S) && (r_rr_cnt < C_MAX_RR);

   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = TIMEOUT_CYC;
      w_tmr_dec  = 1'b0;
      case (r_state)
         ST_START: w_tmr_load = 1'b1;
         ST_WAIT: begin
            // A result arriving while the timer reads zero still counts
            if (!bus.meas_done) begin
               if (w_tmr_zero) begin
                  w_tmr_load = 1'b1;
                  w_tmr_val  = {1'b0, GAP_CYC};
               end else begin
                  w_tmr_dec = 1'b1;
               end
            end
         end
         ST_EVAL: begin
            if (!w_rr_down && !w_rr_up) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = {1'b0, GAP_CYC};
            end
         end
         ST_GAP:  w_tmr_dec = 1'b1;
         default: w_tmr_load = 1'b0;
      endcase
   end

   sched_timer #(
      .WIDTH (C_TMR_W)
   ) u_timer (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state      <= ST_IDLE;
         r_gate       <= GATE_100MS;
         r_rr_cnt     <= 2'd0;
         r_data       <= 20'd0;
         r_ovf        <= 1'b0;
         r_meas_start <= 1'b0;
         r_meas_abort <= 1'b0;
         r_disp_data  <= 20'd0;
         r_disp_valid <= 1'b0;
         r_no_signal  <= 1'b0;
      end else begin
         r_meas_start <= 1'b0;
         r_meas_abort <= 1'b0;
         case (r_state)
            ST_IDLE: r_state <= ST_START;
            ST_START: begin
               r_meas_start <= 1'b1;
               r_state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.meas_done) begin
                  r_data  <= bus.meas_data;
                  r_ovf   <= bus.meas_ovf;
                  r_state <= ST_EVAL;
               end else if (w_tmr_zero) begin
                  r_meas_abort <= 1'b1;
                  r_no_signal  <= 1'b1;
                  if (!hold) begin
                     r_disp_data <= 20'd0;
                  end
                  r_state <= ST_GAP;
               end
            end
            ST_EVAL: begin
               if (w_rr_down) begin
                  r_gate   <= r_gate - 2'd1;
                  r_rr_cnt <= r_rr_cnt + 2'd1;
                  r_state  <= ST_START;
               end else if (w_rr_up) begin
                  r_gate   <= r_gate + 2'd1;
                  r_rr_cnt <= r_rr_cnt + 2'd1;
                  r_state  <= ST_START;
               end else begin
                  if (!hold) begin
                     r_disp_data  <= r_ovf ? C_OVF_DISP : r_data;
                     r_disp_valid <= 1'b1;
                  end
                  r_no_signal <= 1'b0;
                  r_rr_cnt    <= 2'd0;
                  r_state     <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (w_tmr_zero) begin
                  r_state <= ST_START;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.meas_start = r_meas_start;
   assign bus.meas_abort = r_meas_abort;
   assign bus.gate_sel   = r_gate;
   assign disp_data      = r_disp_data;
   assign disp_valid     = r_disp_valid;
   assign no_signal      = r_no_signal;

endmodule : cymometer_sched
`default_nettype wire

// File: tb/tb_cymometer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cymometer_sched                                           |
// | Description : Self-checking bench for cymometer_sched. A transaction-level |
// |               model tracks gate, re-range budget and display state; the   |
// |               bench plays the counter core with directed and random       |
// |               result timing.                                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cymometer_sched;

   localparam int TMO   = 200;
   localparam int GAP   = 20;
   localparam int MAXRR = 2;
   localparam int LO    = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hold;
   logic [19:0] disp_data;
   logic        disp_valid;
   logic        no_signal;

   cymometer_sched_if bus_if ();

   cymometer_sched #(
      .GAP_CYC     (26'd20),
      .TIMEOUT_CYC (27'd200),
      .LO_THRESH   (20'd1000),
      .MAX_RERANGE (2)
   ) dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .hold       (hold),
      .bus        (bus_if),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .no_signal  (no_signal)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_both   = 0;
   int n_badg   = 0;

   // Reference model state
   int          m_gate;
   int          m_rr;
   logic [19:0] m_disp;
   logic        m_valid;
   logic        m_nosig;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus_if.meas_start && bus_if.meas_abort) n_both++;
         if (bus_if.gate_sel === 2'd3) n_badg++;
      end
   end

   task automatic model_reset();
      m_gate  = 1;
      m_rr    = 0;
      m_disp  = 20'd0;
      m_valid = 1'b0;
      m_nosig = 1'b0;
   endtask

   // Applies one completed result to the model; reports whether it re-ranged
   task automatic model_result(input logic [19:0] d, input logic ovf, input logic hv,
                               output bit rer);
      rer = 1'b1;
      if (ovf && m_gate > 0 && m_rr < MAXRR) begin
         m_gate--;
         m_rr++;
      end else if (int'(d) < LO && m_gate < 2 && m_rr < MAXRR) begin
         m_gate++;
         m_rr++;
      end else begin
         rer = 1'b0;
         if (!hv) begin
            m_disp  = ovf ? 20'hFFFFF : d;
            m_valid = 1'b1;
         end
         m_nosig = 1'b0;
         m_rr    = 0;
      end
   endtask

   // Assert reset, check reset outputs, release and check first-start latency
   task automatic reset_seq();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_meas_start", bus_if.meas_start, 0);
      chk("rst_meas_abort", bus_if.meas_abort, 0);
      chk("rst_gate_sel",   bus_if.gate_sel,   1);
      chk("rst_disp_data",  disp_data,         0);
      chk("rst_disp_valid", disp_valid,        0);
      chk("rst_no_signal",  no_signal,         0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      chk("start_cyc1", bus_if.meas_start, 0);
      @(negedge clk);
      chk("start_cyc2", bus_if.meas_start, 1);
   endtask

   task automatic wait_start();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus_if.meas_start) begin
            ok = 1'b1;
            break;
         end
      end
      chk("start_seen", ok, 1);
   endtask

   // One measurement as seen by the core. Called with the meas_start cycle
   // being sampled (skip=1) or before it (skip=0). dly is the number of
   // cycles after meas_start at which meas_done is driven.
   task automatic do_meas(input bit skip, input int dly, input logic [19:0] d,
                          input logic ovf, input logic hv, input bit tmo, input bit stray);
      int n_ab;
      int ab_at;
      bit rer;
      if (!skip) wait_start();
      chk("gate_sel", bus_if.gate_sel, m_gate);
      hold  = hv;
      n_ab  = 0;
      ab_at = -1;
      rer   = 1'b0;
      if (tmo) begin
         for (int i = 1; i <= TMO + 5; i++) begin
            @(negedge clk);
            if (bus_if.meas_abort) begin
               n_ab++;
               if (ab_at < 0) ab_at = i;
            end
         end
         m_nosig = 1'b1;
         if (!hv) m_disp = 20'd0;
         chk("abort_count", n_ab, 1);
         chk("abort_time", (ab_at == TMO || ab_at == TMO + 1), 1);
      end else begin
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (bus_if.meas_abort) n_ab++;
         end
         bus_if.meas_done = 1'b1;
         bus_if.meas_data = d;
         bus_if.meas_ovf  = ovf;
         @(negedge clk);
         if (bus_if.meas_abort) n_ab++;
         bus_if.meas_done = 1'b0;
         bus_if.meas_data = 20'($urandom);
         bus_if.meas_ovf  = 1'($urandom);
         @(negedge clk);
         if (bus_if.meas_abort) n_ab++;
         chk("no_abort", n_ab, 0);
         model_result(d, ovf, hv, rer);
      end
      chk("disp_data",  disp_data,  m_disp);
      chk("disp_valid", disp_valid, m_valid);
      chk("no_signal",  no_signal,  m_nosig);
      // A result pulse during GAP must be ignored
      if (stray && !rer) begin
         bus_if.meas_done = 1'b1;
         bus_if.meas_data = 20'($urandom);
         @(negedge clk);
         bus_if.meas_done = 1'b0;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [19:0] d;
      rst_n            = 1'b0;
      hold             = 1'b0;
      bus_if.meas_done = 1'b0;
      bus_if.meas_data = 20'd0;
      bus_if.meas_ovf  = 1'b0;
      model_reset();

      reset_seq();
      do_meas(1'b1, 50, 20'd500000, 1'b0, 1'b0, 1'b0, 1'b0);
      // Low result ranges up, then publishes
      do_meas(1'b0, 30, 20'd300,    1'b0, 1'b0, 1'b0, 1'b0);
      do_meas(1'b0, 40, 20'd3000,   1'b0, 1'b0, 1'b0, 1'b0);
      // Three overflows from the 1 s gate
      do_meas(1'b0, 10, 20'h12345,  1'b1, 1'b0, 1'b0, 1'b0);
      do_meas(1'b0, 10, 20'h12345,  1'b1, 1'b0, 1'b0, 1'b0);
      do_meas(1'b0, 10, 20'h12345,  1'b1, 1'b0, 1'b0, 1'b0);
      // Timeout, then recovery
      do_meas(1'b0, 0,  20'd0,      1'b0, 1'b0, 1'b1, 1'b0);
      do_meas(1'b0, 20, 20'd700000, 1'b0, 1'b0, 1'b0, 1'b0);
      // Hold freezes the display
      do_meas(1'b0, 25, 20'd1234,   1'b0, 1'b1, 1'b0, 1'b0);
      do_meas(1'b0, 25, 20'd4321,   1'b0, 1'b0, 1'b0, 1'b1);
      // Result in the cycle the timer reads zero
      do_meas(1'b0, TMO, 20'd88888, 1'b0, 1'b0, 1'b0, 1'b0);
      // Reset in the middle of WAIT
      wait_start();
      repeat (10) @(negedge clk);
      reset_seq();
      do_meas(1'b1, 15, 20'd55555,  1'b0, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0) d = 20'($urandom_range(0, 1999));
         else                           d = 20'($urandom);
         do_meas(1'b0, int'($urandom_range(0, TMO)), d,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom));
      end

      chk("start_abort_overlap", n_both, 0);
      chk("illegal_gate",        n_badg, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_cymometer_sched
`default_nettype wire
